// File: rtl/apb_mem_completer_if.sv
// Request/response types and the APB bus bundle between a manager and apb_mem_completer.
package apb_mem_completer_pkg;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        write;
    logic [3:0]  strb;
    logic [2:0]  prot;
  } apb_req_t;

  typedef struct packed {
    logic [31:0] rdata;
  } apb_resp_t;

endpackage

interface apb_mem_completer_if;
  import apb_mem_completer_pkg::*;

  apb_req_t  i_apb_s_req;
  logic      i_apb_s_psel;
  logic      i_apb_s_penable;
  apb_resp_t o_apb_s_resp;
  logic      o_apb_s_pready;
  logic      o_apb_s_pslverr;

  modport master (
    output i_apb_s_req, i_apb_s_psel, i_apb_s_penable,
    input  o_apb_s_resp, o_apb_s_pready, o_apb_s_pslverr
  );

  modport slave (
    input  i_apb_s_req, i_apb_s_psel, i_apb_s_penable,
    output o_apb_s_resp, o_apb_s_pready, o_apb_s_pslverr
  );

endinterface

// File: rtl/apb_mem_completer.sv
// APB completer backed by a byte-writable word memory, with fixed or LFSR-driven wait states.
module apb_mem_completer
  import apb_mem_completer_pkg::*;
#(
  parameter int          DEPTH       = 1024,
  parameter int          WAIT_CYCLES = 3,
  parameter int          RANDOM_WAIT = 1,
  parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
  input  logic                  clk,
  input  logic                  rst,
  apb_mem_completer_if.slave    apb,
  output logic [31:0]           o_xfer_count
);

  localparam int         AW       = $clog2(DEPTH);
  localparam logic [3:0] WAIT_MAX = 4'(WAIT_CYCLES);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_READY} state_t;

  state_t        state, state_nxt;
  apb_req_t      req_q, req_cur;
  logic [3:0]    cnt_q, cnt_nxt, wait_w;
  logic [15:0]   lfsr_q;
  logic          setup, complete, enter_ready, out_of_range;
  logic [AW-1:0] index;
  logic          pready_q, pslverr_q;
  logic [31:0]   rdata_q;
  logic [31:0]   mem [DEPTH];

  // In IDLE the incoming request is the one being decoded; afterwards only the latched copy counts.
  assign req_cur      = (state == S_IDLE) ? apb.i_apb_s_req : req_q;
  assign index        = req_cur.addr[2 +: AW];
  assign out_of_range = (req_cur.addr >> (AW + 2)) != 32'd0;

  assign wait_w = (RANDOM_WAIT == 0)       ? WAIT_MAX :
                  (lfsr_q[3:0] < WAIT_MAX) ? lfsr_q[3:0] : WAIT_MAX;

  always_comb begin
    // NOTE: every output of this block gets a default first so no path can infer a latch.
    state_nxt = state;
    cnt_nxt   = cnt_q;
    setup     = 1'b0;
    complete  = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (apb.i_apb_s_psel && !apb.i_apb_s_penable) begin
          setup = 1'b1;
          if (wait_w == 4'd0) begin
            state_nxt = S_READY;
          end else begin
            state_nxt = S_WAIT;
            cnt_nxt   = wait_w;
          end
        end
      end
      S_WAIT: begin
        if (!apb.i_apb_s_psel) begin
          state_nxt = S_IDLE;
        end else if (apb.i_apb_s_penable) begin
          cnt_nxt = cnt_q - 4'd1;
          if (cnt_q == 4'd1) state_nxt = S_READY;
        end
      end
      S_READY: begin
        if (!apb.i_apb_s_psel) begin
          state_nxt = S_IDLE;
        end else if (apb.i_apb_s_penable) begin
          complete  = 1'b1;
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  assign enter_ready = (state_nxt == S_READY) && (state != S_READY);

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_IDLE;
      cnt_q        <= '0;
      lfsr_q       <= LFSR_SEED;
      req_q        <= '0;
      pready_q     <= 1'b0;
      pslverr_q    <= 1'b0;
      rdata_q      <= '0;
      o_xfer_count <= '0;
    end else begin
      state    <= state_nxt;
      cnt_q    <= cnt_nxt;
      pready_q <= (state_nxt == S_READY);
      if (setup) begin
        req_q  <= apb.i_apb_s_req;
        lfsr_q <= {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};
      end
      if (enter_ready) begin
        pslverr_q <= out_of_range;
        rdata_q   <= out_of_range ? 32'd0 : mem[index];
      end else if (state_nxt != S_READY) begin
        pslverr_q <= 1'b0;
      end
      if (complete) o_xfer_count <= o_xfer_count + 32'd1;
    end
  end

  // NOTE: the memory is deliberately reset word by word, so it is built from flops rather than RAM.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (complete && req_q.write && !out_of_range) begin
      for (int b = 0; b < 4; b++) begin
        if (req_q.strb[b]) mem[index][8*b +: 8] <= req_q.wdata[8*b +: 8];
      end
    end
  end

  assign apb.o_apb_s_pready     = pready_q;
  assign apb.o_apb_s_pslverr    = pslverr_q;
  assign apb.o_apb_s_resp.rdata = rdata_q;

  // prot and the byte offset have no effect on this completer.
  logic unused_ok;
  assign unused_ok = &{1'b0, req_q.prot, req_q.addr[1:0], apb.i_apb_s_req.prot};

endmodule
